// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: sequences a single-step external ALU, iterating shifts by feeding the result back
module alu_seq_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [2:0]  cmd_op,
   input  logic [31:0] cmd_a,
   input  logic [31:0] cmd_b,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [2:0]  alu_sel,
   input  logic [31:0] alu_out,
   input  logic        carry_out,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [31:0] res_data,
   output logic        res_carry,
   output logic        busy,
   output logic [15:0] op_count
);
   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
   state_t state, state_nx;
   logic [4:0] cnt;
   logic bypass, accept, last, take, is_shift;
   assign is_shift = cmd_op[2:1] == 2'b11;
   assign accept = cmd_valid & cmd_ready;
   assign last = (state == EXEC) && (cnt == 5'd1);
   assign take = (state == DONE) && res_ready;
   always_comb begin
      state_nx = accept ? EXEC : last ? DONE : take ? IDLE : state;
      cmd_ready = (state == IDLE) & ~rst;
      res_valid = state == DONE;
      busy = state != IDLE;
   end
   // alu_a doubles as the working register, so it holds its last value outside EXEC
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt <= '0;
         bypass <= 1'b0;
         alu_a <= '0;
         alu_b <= '0;
         alu_sel <= '0;
         res_data <= '0;
         res_carry <= 1'b0;
         op_count <= '0;
      end else begin
         state <= state_nx;
         if (accept) begin
            alu_sel <= cmd_op;
            alu_a <= cmd_a;
            alu_b <= cmd_b;
            bypass <= is_shift && (cmd_b[4:0] == 5'd0);
            cnt <= (is_shift && (cmd_b[4:0] != 5'd0)) ? cmd_b[4:0] : 5'd1;
         end
         if (state == EXEC) begin
            alu_a <= alu_out;
            cnt <= cnt - 5'd1;
         end
         if (last) begin
            res_data <= bypass ? alu_a : alu_out;
            res_carry <= ~bypass && (alu_sel == 3'b000) && carry_out;
         end
         if (take) op_count <= op_count + 16'd1;
      end
   end
endmodule

// File: doc/alu_seq_ctrl.md
ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 SHALL use one clock and an asynchronous, active-high reset, as follows: clk  input  1  rising-edge clock; rst  input  1  asynchronous active-high reset.
REQ-002 SHALL have port cmd_valid  input  1  command offered.
REQ-003 SHALL have port cmd_ready  output  1  command accepted when high with cmd_valid.
REQ-004 SHALL have port cmd_op  input  3  ALU opcode: 000 add, 001 sub, 010 not, 011 and, 100 or, 101 xor, 110 sll, 111 srl.
REQ-005 SHALL have ports cmd_a and cmd_b  input  32  operands; for 110/111, cmd_b[4:0] is the shift amount.
REQ-006 SHALL have ports alu_a, alu_b  output  32  and alu_sel  output  3, which drive the 32-bit single-step ALU's a, b and alu_sel inputs.
REQ-007 SHALL have ports alu_out  input  32  and carry_out  input  1, returned from the ALU.
REQ-008 SHALL have ports res_valid  output  1, res_ready  input  1, res_data  output  32 and res_carry  output  1, forming the result handshake.
REQ-009 SHALL have port busy  output  1, high whenever state is not IDLE.
REQ-010 SHALL have port op_count  output  16, the count of completed results.

Function
REQ-011 SHALL implement the states IDLE, EXEC and DONE.
REQ-012 SHALL assert cmd_ready only in IDLE and only while rst is low; cmd_* SHALL be sampled only on an accepting edge (cmd_valid & cmd_ready), and cmd_valid SHALL be ignored at all other times.
REQ-013 On acceptance SHALL latch op, a and b into internal registers, load the iteration count N, and go to EXEC.
REQ-014 N SHALL be 1 for ops 000-101, and cmd_b[4:0] for ops 110/111, with a shift amount of 0 treated as N=1 plus a bypass flag.
REQ-015 In EXEC SHALL drive alu_a = working register (initially latched a), alu_b = latched b, and alu_sel = latched op.
REQ-016 On each EXEC edge SHALL load alu_out into the working register and decrement the remaining count.
REQ-017 SHALL iterate shifts by feeding the result back, so k EXEC cycles yield a shift by k.
REQ-018 When the final iteration completes, SHALL register res_data from alu_out and go to DONE; for bypass, res_data SHALL equal latched a and the ALU result SHALL be discarded.
REQ-019 res_carry SHALL equal carry_out sampled on the final EXEC cycle when op=000; it SHALL be 0 for all other ops and for bypass.
REQ-020 Latency SHALL be: for acceptance at edge k, res_valid high from edge k+N (k+1 for bypass); there SHALL be no combinational path from cmd_* to res_*.
REQ-021 In DONE SHALL hold res_valid=1, and res_data and res_carry stable, until res_ready is high on an edge; that edge SHALL return to IDLE, clear res_valid, and increment op_count.
REQ-022 op_count SHALL wrap 16'hFFFF -> 16'h0000.
REQ-023 SHALL not accept a new command in the same cycle a result is taken; the next acceptance is possible at the earliest one edge after the return to IDLE.
REQ-024 SHALL hold alu_a, alu_b and alu_sel at their last values in IDLE and DONE.
REQ-025 SHALL ignore res_ready outside DONE.

Reset
REQ-026 rst high SHALL immediately force, regardless of clk: state IDLE; res_valid, res_data, res_carry, busy, op_count, alu_a, alu_b, alu_sel and all internal registers = 0; cmd_ready = 0.
REQ-027 Reset during EXEC or DONE SHALL abort the operation, produce no result, and leave no pending state.
REQ-028 After rst deasserts, cmd_ready SHALL be 1 from the first cycle, and the first acceptance is possible on the first rising edge.

Verification
REQ-029 SHALL verify reset: rst pulse mid-sim -> res_valid=0, busy=0, op_count=0, cmd_ready=0 during rst, cmd_ready=1 after release.
REQ-030 SHALL verify sub: op=001, a=5, b=3 accepted at edge k -> alu_sel=001 during EXEC, res_valid at k+1, res_data=2, res_carry=0.
REQ-031 SHALL verify add carry: op=000, a=32'hFFFFFFFF, b=1 -> res_data=0, res_carry equal to ALU carry_out sampled in EXEC, latency 1.
REQ-032 SHALL verify shifts: op=110, a=1, b=4 -> 4 EXEC cycles, res_data=32'h10 at k+4; op=111, a=32'h80000000, b=31 -> res_data=1 at k+31; op=110, a=32'hA5, b=32'h20 -> bypass, res_data=32'hA5 at k+1.
REQ-033 SHALL verify backpressure: res_ready low 5 cycles in DONE with cmd_valid high -> res_data stable, cmd_ready=0, no acceptance; res_ready high -> op_count +1 exactly once, and acceptance no earlier than the following edge.
REQ-034 SHALL verify reset mid-operation and wrap: rst asserted on the 3rd EXEC cycle of sll by 10 -> no res_valid, IDLE, op_count=0; separately, 65536 completed ops -> op_count=0.
